// File: rtl/dma_pkg.sv
// Shared DMA definitions: channel count, channel index width and the
// service-controller state encoding used by the priority tree and address/count block.
package dma_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE,
        HREQ,
        XFER,
        RELEASE
    } dma_state_t;

endpackage

// File: rtl/dma_onehot_enc.sv
// One-hot to binary channel encoder; on a multi-hot input the highest set index wins.
module dma_onehot_enc #(
    parameter int NCH = dma_pkg::NCH,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  onehot,
    output logic [CH_W-1:0] idx
);

    // Later iterations overwrite earlier ones, so the highest index sticks.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (onehot[i]) begin
                idx = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/dma_service_ctrl.sv
// DMA channel-service controller: latches the granted channel, runs the HRQ/HLDA
// handshake, strobes DACK/xfer, and tracks sticky TC status and the last serviced channel.
module dma_service_ctrl
    import dma_pkg::*;
#(
    parameter int NCH = dma_pkg::NCH,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_up,
    input  logic [NCH-1:0]  grant,
    input  logic [NCH-1:0]  dreq,
    input  logic [NCH-1:0]  demand,
    input  logic            rot_en,
    input  logic            tc,
    input  logic            eop_n,
    input  logic            hlda,
    input  logic            status_rd,
    output logic            hrq,
    output logic [NCH-1:0]  dack,
    output logic            xfer,
    output logic [CH_W-1:0] chan,
    output logic            prio_en,
    output logic [CH_W-1:0] last_ch,
    output logic [NCH-1:0]  tc_status
);

    dma_state_t      state;
    dma_state_t      state_nxt;
    logic [CH_W-1:0] grant_idx;
    logic            set_tc;
    logic [NCH-1:0]  tc_status_nxt;

    dma_onehot_enc #(.NCH(NCH)) u_grant_enc (
        .onehot (grant),
        .idx    (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            chan      <= '0;
            last_ch   <= CH_W'(NCH - 1);
            tc_status <= '0;
        end else begin
            state     <= state_nxt;
            tc_status <= tc_status_nxt;
            if (state == IDLE && req_up && (|grant)) begin
                chan <= grant_idx;
            end
            if (state == RELEASE && rot_en) begin
                last_ch <= chan;
            end
        end
    end

    // Exit checks in XFER are ordered: HLDA loss aborts before TC/EOP can mark status.
    always_comb begin
        state_nxt = state;
        set_tc    = 1'b0;
        case (state)
            IDLE: begin
                if (req_up && (|grant)) begin
                    state_nxt = HREQ;
                end
            end
            HREQ: begin
                if (hlda) begin
                    state_nxt = XFER;
                end else if (!dreq[chan]) begin
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (!hlda) begin
                    state_nxt = RELEASE;
                end else if (tc || !eop_n) begin
                    set_tc    = 1'b1;
                    state_nxt = RELEASE;
                end else if (!demand[chan] || !dreq[chan]) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!hlda) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A status read clears every bit except one being set on this same edge.
    always_comb begin
        tc_status_nxt = status_rd ? '0 : tc_status;
        if (set_tc) begin
            tc_status_nxt[chan] = 1'b1;
        end
    end

    always_comb begin
        dack = '0;
        if (state == XFER) begin
            dack[chan] = 1'b1;
        end
    end

    assign hrq     = (state == HREQ) || (state == XFER);
    assign xfer    = (state == XFER);
    assign prio_en = (state == IDLE);

endmodule

// File: tb/tb_dma_service_ctrl.sv
// Scenario bench for dma_service_ctrl: per-feature tasks with inline checks plus a
// burst scoreboard matching each observed xfer burst against the expected channel/length.
module tb_dma_service_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_up = 1'b0;
    logic [3:0] grant = '0;
    logic [3:0] dreq = '0;
    logic [3:0] demand = '0;
    logic       rot_en = 1'b0;
    logic       tc = 1'b0;
    logic       eop_n = 1'b1;
    logic       hlda = 1'b0;
    logic       status_rd = 1'b0;
    logic       hrq;
    logic [3:0] dack;
    logic       xfer;
    logic [1:0] chan;
    logic       prio_en;
    logic [1:0] last_ch;
    logic [3:0] tc_status;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ch;
        int len;
    } burst_t;

    burst_t sb[$];

    dma_service_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_up    (req_up),
        .grant     (grant),
        .dreq      (dreq),
        .demand    (demand),
        .rot_en    (rot_en),
        .tc        (tc),
        .eop_n     (eop_n),
        .hlda      (hlda),
        .status_rd (status_rd),
        .hrq       (hrq),
        .dack      (dack),
        .xfer      (xfer),
        .chan      (chan),
        .prio_en   (prio_en),
        .last_ch   (last_ch),
        .tc_status (tc_status)
    );

    always #5 clk = ~clk;

    // Burst monitor: measures each run of xfer cycles and scores it against the queue.
    int         burst_len = 0;
    logic [3:0] burst_dack = '0;
    logic       burst_bad = 1'b0;

    always @(negedge clk) begin
        checks++;
        if ((dack != 4'b0) && (!xfer || prio_en)) begin
            errors++;
            $display("FAIL dack_outside_xfer: dack=%b xfer=%b prio_en=%b", dack, xfer, prio_en);
        end
        if (xfer) begin
            if (burst_len == 0) burst_dack = dack;
            else if (dack !== burst_dack) burst_bad = 1'b1;
            burst_len++;
        end else if (burst_len > 0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_burst: dack=%b len=%0d, none expected", burst_dack, burst_len);
            end else begin
                burst_t     e;
                logic [3:0] exp_dack;
                e = sb.pop_front();
                exp_dack = 4'(1 << e.ch);
                if (burst_dack !== exp_dack || burst_len != e.len || burst_bad) begin
                    errors++;
                    $display("FAIL burst: dack=%b len=%0d unstable=%b, expected dack=%b len=%0d",
                             burst_dack, burst_len, burst_bad, exp_dack, e.len);
                end
            end
            burst_len = 0;
            burst_bad = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (hrq !== 1'b0 || dack !== 4'b0 || xfer !== 1'b0 || chan !== 2'd0 ||
            last_ch !== 2'd3 || tc_status !== 4'b0 || prio_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: hrq=%b dack=%b xfer=%b chan=%0d last_ch=%0d tc_status=%b prio_en=%b, expected 0 0000 0 0 3 0000 1",
                     hrq, dack, xfer, chan, last_ch, tc_status, prio_en);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rot_en = 1'b1;
        demand = 4'b0000;
        dreq   = 4'b0100;
        grant  = 4'b0100;
        req_up = 1'b1;
        tick();
        checks++;
        if (hrq !== 1'b1 || chan !== 2'd2 || prio_en !== 1'b0) begin
            errors++;
            $display("FAIL single_hreq: hrq=%b chan=%0d prio_en=%b, expected 1 2 0", hrq, chan, prio_en);
        end
        grant  = '0;
        req_up = 1'b0;
        sb.push_back('{ch: 2, len: 1});
        tick();
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if (xfer !== 1'b1 || dack !== 4'b0100) begin
            errors++;
            $display("FAIL single_xfer: xfer=%b dack=%b, expected 1 0100", xfer, dack);
        end
        tick();
        checks++;
        if (xfer !== 1'b0 || hrq !== 1'b0 || dack !== 4'b0) begin
            errors++;
            $display("FAIL single_release: xfer=%b hrq=%b dack=%b, expected 0 0 0000", xfer, hrq, dack);
        end
        hlda = 1'b0;
        tick();
        checks++;
        if (last_ch !== 2'd2 || prio_en !== 1'b1 || chan !== 2'd2) begin
            errors++;
            $display("FAIL single_done: last_ch=%0d prio_en=%b chan=%0d, expected 2 1 2", last_ch, prio_en, chan);
        end
        dreq = '0;
    endtask

    task automatic test_demand_tc();
        demand = 4'b0010;
        dreq   = 4'b0010;
        grant  = 4'b0010;
        req_up = 1'b1;
        tick();
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 1, len: 5});
        tick();
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (xfer !== 1'b1 || dack !== 4'b0010) begin
                errors++;
                $display("FAIL demand_burst_cycle%0d: xfer=%b dack=%b, expected 1 0010", i, xfer, dack);
            end
            if (i == 5) tc = 1'b1;
            tick();
        end
        tc = 1'b0;
        checks++;
        if (xfer !== 1'b0 || hrq !== 1'b0 || tc_status !== 4'b0010) begin
            errors++;
            $display("FAIL demand_tc_release: xfer=%b hrq=%b tc_status=%b, expected 0 0 0010", xfer, hrq, tc_status);
        end
        hlda = 1'b0;
        tick();
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
        checks++;
        if (tc_status !== 4'b0000) begin
            errors++;
            $display("FAIL status_rd_clear: tc_status=%b, expected 0000", tc_status);
        end
        dreq   = '0;
        demand = '0;
    endtask

    task automatic test_withdraw();
        demand = 4'b0000;
        dreq   = 4'b1000;
        grant  = 4'b1000;
        req_up = 1'b1;
        tick();
        checks++;
        if (hrq !== 1'b1 || chan !== 2'd3) begin
            errors++;
            $display("FAIL withdraw_hreq: hrq=%b chan=%0d, expected 1 3", hrq, chan);
        end
        grant  = '0;
        req_up = 1'b0;
        dreq   = '0;
        tick();
        checks++;
        if (hrq !== 1'b0 || prio_en !== 1'b1 || dack !== 4'b0) begin
            errors++;
            $display("FAIL withdraw_idle: hrq=%b prio_en=%b dack=%b, expected 0 1 0000", hrq, prio_en, dack);
        end
        tick();
        checks++;
        if (last_ch !== 2'd1) begin
            errors++;
            $display("FAIL withdraw_last_ch: last_ch=%0d, expected 1", last_ch);
        end
    endtask

    task automatic test_hlda_loss();
        demand = 4'b0010;
        dreq   = 4'b0010;
        grant  = 4'b0010;
        req_up = 1'b1;
        tick();
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 1, len: 3});
        tick();
        tick();
        tick();
        hlda = 1'b0;
        tick();
        checks++;
        if (xfer !== 1'b0 || hrq !== 1'b0) begin
            errors++;
            $display("FAIL hlda_loss_release: xfer=%b hrq=%b, expected 0 0", xfer, hrq);
        end
        tick();
        checks++;
        if (tc_status !== 4'b0000 || prio_en !== 1'b1) begin
            errors++;
            $display("FAIL hlda_loss_status: tc_status=%b prio_en=%b, expected 0000 1", tc_status, prio_en);
        end
        dreq   = '0;
        demand = '0;
    endtask

    task automatic test_eop_status();
        demand = 4'b0000;
        dreq   = 4'b1000;
        grant  = 4'b1000;
        req_up = 1'b1;
        tick();
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 3, len: 1});
        tick();
        tc = 1'b1;
        tick();
        tc = 1'b0;
        checks++;
        if (tc_status !== 4'b1000) begin
            errors++;
            $display("FAIL tc_single_ch3: tc_status=%b, expected 1000", tc_status);
        end
        hlda = 1'b0;
        tick();
        dreq   = 4'b0001;
        demand = 4'b0001;
        grant  = 4'b0001;
        req_up = 1'b1;
        rot_en = 1'b0;
        tick();
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 0, len: 2});
        tick();
        tick();
        eop_n     = 1'b0;
        status_rd = 1'b1;
        tick();
        eop_n     = 1'b1;
        status_rd = 1'b0;
        checks++;
        if (tc_status !== 4'b0001 || xfer !== 1'b0) begin
            errors++;
            $display("FAIL eop_set_wins: tc_status=%b xfer=%b, expected 0001 0", tc_status, xfer);
        end
        hlda = 1'b0;
        tick();
        checks++;
        if (last_ch !== 2'd3) begin
            errors++;
            $display("FAIL rot_en_off_last_ch: last_ch=%0d, expected 3", last_ch);
        end
        rot_en = 1'b1;
        dreq   = '0;
        demand = '0;
    endtask

    task automatic test_reset_mid();
        demand = 4'b0100;
        dreq   = 4'b0100;
        grant  = 4'b0100;
        req_up = 1'b1;
        tick();
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 2, len: 2});
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (hrq !== 1'b0 || dack !== 4'b0 || xfer !== 1'b0 || last_ch !== 2'd3 ||
            tc_status !== 4'b0 || chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_xfer: hrq=%b dack=%b xfer=%b last_ch=%0d tc_status=%b chan=%0d, expected 0 0000 0 3 0000 0",
                     hrq, dack, xfer, last_ch, tc_status, chan);
        end
        rst    = 1'b1;
        hlda   = 1'b0;
        dreq   = '0;
        demand = '0;
        tick();
    endtask

    task automatic test_multihot();
        grant  = 4'b0010;
        req_up = 1'b0;
        tick();
        checks++;
        if (hrq !== 1'b0 || prio_en !== 1'b1) begin
            errors++;
            $display("FAIL no_req_up_stays_idle: hrq=%b prio_en=%b, expected 0 1", hrq, prio_en);
        end
        demand = 4'b0000;
        dreq   = 4'b0100;
        grant  = 4'b0101;
        req_up = 1'b1;
        tick();
        checks++;
        if (chan !== 2'd2 || hrq !== 1'b1) begin
            errors++;
            $display("FAIL multihot_chan: chan=%0d hrq=%b, expected 2 1", chan, hrq);
        end
        grant  = '0;
        req_up = 1'b0;
        hlda   = 1'b1;
        sb.push_back('{ch: 2, len: 1});
        tick();
        checks++;
        if (dack !== 4'b0100) begin
            errors++;
            $display("FAIL multihot_dack: dack=%b, expected 0100", dack);
        end
        tick();
        hlda = 1'b0;
        tick();
        dreq = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_demand_tc();
        test_withdraw();
        test_hlda_loss();
        test_eop_status();
        test_reset_mid();
        test_multihot();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bursts outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
